// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register-file geometry, scoreboard counter widths
// and the slot numbering used by the flush unit's kill bus.
package pipe_pkg;
    localparam int REG_W       = 5;
    localparam int NREG        = 32;
    localparam int CNT_W       = 2;
    localparam int TOT_W       = 3;
    localparam int KILL_IDEXE  = 0;
    localparam int KILL_EXEMEM = 1;
endpackage

// File: rtl/sb_cnt_cell.sv
// One register's pending-write counter: sums this cycle's increments and
// decrements, clamps to [0, 2^CNT_W-1] and flags any clamp on err.
module sb_cnt_cell #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] counter,
    output logic             nonzero,
    output logic             err
);
    localparam int SW = CNT_W + 2;
    localparam logic signed [SW-1:0] MAX_S = {2'b00, {CNT_W{1'b1}}};

    logic signed [SW-1:0] sum;
    logic [CNT_W-1:0]     counter_nxt;

    always_comb begin
        sum         = $signed({2'b00, counter})
                    + $signed({{CNT_W{1'b0}}, inc})
                    - $signed({{CNT_W{1'b0}}, dec});
        counter_nxt = sum[CNT_W-1:0];
        err         = 1'b0;
        if (sum > MAX_S) begin
            counter_nxt = {CNT_W{1'b1}};
            err         = 1'b1;
        end else if (sum < 0) begin
            counter_nxt = '0;
            err         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) counter <= '0;
        else        counter <= counter_nxt;
    end

    assign nonzero = |counter;
endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard beside ID: issue marks rd busy,
// writeback and flush kills release it, and reads of busy registers stall ID.
module reg_scoreboard #(
    parameter int NREG  = pipe_pkg::NREG,
    parameter int CNT_W = pipe_pkg::CNT_W,
    parameter int TOT_W = pipe_pkg::TOT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    input  logic                       issue_we,
    input  logic [pipe_pkg::REG_W-1:0] issue_rd,
    input  logic                       wb_valid,
    input  logic                       wb_we,
    input  logic [pipe_pkg::REG_W-1:0] wb_rd,
    input  logic [1:0]                 kill_valid,
    input  logic [pipe_pkg::REG_W-1:0] kill_rd0,
    input  logic [pipe_pkg::REG_W-1:0] kill_rd1,
    input  logic                       rf_re,
    input  logic [pipe_pkg::REG_W-1:0] rf_rd_regnum_1,
    input  logic [pipe_pkg::REG_W-1:0] rf_rd_regnum_2,
    output logic                       data_stall_flag,
    output logic [NREG-1:0]            busy_vec,
    output logic [TOT_W-1:0]           inflight_cnt,
    output logic                       sb_err
);
    import pipe_pkg::*;

    // Event qualifiers: each valid is a single-cycle strobe with no back-pressure,
    // and any event addressed to x0 is dropped before it reaches a counter.
    logic issue_hit, wb_hit, k0_hit, k1_hit;
    assign issue_hit = issue_valid & issue_we & (issue_rd != '0);
    assign wb_hit    = wb_valid & wb_we & (wb_rd != '0);
    assign k0_hit    = kill_valid[KILL_IDEXE]  & (kill_rd0 != '0);
    assign k1_hit    = kill_valid[KILL_EXEMEM] & (kill_rd1 != '0);

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  cell_err;

    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;
    assign cell_err[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cell
        logic [1:0] inc_n, dec_n;
        assign inc_n = {1'b0, issue_hit & (issue_rd == REG_W'(r))};
        assign dec_n = {1'b0, wb_hit & (wb_rd == REG_W'(r))}
                     + {1'b0, k0_hit & (kill_rd0 == REG_W'(r))}
                     + {1'b0, k1_hit & (kill_rd1 == REG_W'(r))};

        sb_cnt_cell #(.CNT_W(CNT_W)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc_n),
            .dec     (dec_n),
            .counter (cnt[r]),
            .nonzero (busy_vec[r]),
            .err     (cell_err[r])
        );
    end

    // Net delta across all registers drives the total, clamped like a cell.
    localparam int TSW = TOT_W + 2;
    localparam logic signed [TSW-1:0] TOT_MAX_S = {2'b00, {TOT_W{1'b1}}};

    logic [1:0]            tot_inc, tot_dec;
    logic signed [TSW-1:0] tot_sum;
    logic [TOT_W-1:0]      tot_nxt;
    logic                  tot_err;

    always_comb begin
        tot_inc = {1'b0, issue_hit};
        tot_dec = {1'b0, wb_hit} + {1'b0, k0_hit} + {1'b0, k1_hit};
        tot_sum = $signed({2'b00, inflight_cnt})
                + $signed({{TOT_W{1'b0}}, tot_inc})
                - $signed({{TOT_W{1'b0}}, tot_dec});
        tot_nxt = tot_sum[TOT_W-1:0];
        tot_err = 1'b0;
        if (tot_sum > TOT_MAX_S) begin
            tot_nxt = {TOT_W{1'b1}};
            tot_err = 1'b1;
        end else if (tot_sum < 0) begin
            tot_nxt = '0;
            tot_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_cnt <= '0;
            sb_err       <= 1'b0;
        end else begin
            inflight_cnt <= tot_nxt;
            sb_err       <= sb_err | (|cell_err) | tot_err;
        end
    end

    // Current counters only: the register file does not bypass writeback data.
    assign data_stall_flag = rf_re &
        (((rf_rd_regnum_1 != '0) & (cnt[rf_rd_regnum_1] != '0)) |
         ((rf_rd_regnum_2 != '0) & (cnt[rf_rd_regnum_2] != '0)));
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed plus randomized checks of reg_scoreboard against an integer
// reference model of pending writes per register.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 0, issue_we = 0;
    logic [4:0]  issue_rd = 0;
    logic        wb_valid = 0, wb_we = 0;
    logic [4:0]  wb_rd = 0;
    logic [1:0]  kill_valid = 0;
    logic [4:0]  kill_rd0 = 0, kill_rd1 = 0;
    logic        rf_re = 0;
    logic [4:0]  rs1 = 0, rs2 = 0;
    logic        data_stall_flag;
    logic [31:0] busy_vec;
    logic [2:0]  inflight_cnt;
    logic        sb_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model
    int m_cnt [32];
    int m_tot;
    bit m_err;

    reg_scoreboard dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_we        (issue_we),
        .issue_rd        (issue_rd),
        .wb_valid        (wb_valid),
        .wb_we           (wb_we),
        .wb_rd           (wb_rd),
        .kill_valid      (kill_valid),
        .kill_rd0        (kill_rd0),
        .kill_rd1        (kill_rd1),
        .rf_re           (rf_re),
        .rf_rd_regnum_1  (rs1),
        .rf_rd_regnum_2  (rs2),
        .data_stall_flag (data_stall_flag),
        .busy_vec        (busy_vec),
        .inflight_cnt    (inflight_cnt),
        .sb_err          (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_tot = 0;
        m_err = 0;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    function automatic logic model_stall();
        return rf_re && ((rs1 != 0 && m_cnt[rs1] != 0) || (rs2 != 0 && m_cnt[rs2] != 0));
    endfunction

    function automatic void model_step();
        int d [32];
        int net;
        for (int r = 0; r < 32; r++) d[r] = 0;
        if (issue_valid && issue_we) d[issue_rd] += 1;
        if (wb_valid && wb_we)       d[wb_rd]    -= 1;
        if (kill_valid[0])           d[kill_rd0] -= 1;
        if (kill_valid[1])           d[kill_rd1] -= 1;
        d[0] = 0;
        net = 0;
        for (int r = 1; r < 32; r++) begin
            int n;
            net += d[r];
            n = m_cnt[r] + d[r];
            if (n > 3)      begin n = 3; m_err = 1; end
            else if (n < 0) begin n = 0; m_err = 1; end
            m_cnt[r] = n;
        end
        m_tot += net;
        if (m_tot > 7)      begin m_tot = 7; m_err = 1; end
        else if (m_tot < 0) begin m_tot = 0; m_err = 1; end
    endfunction

    task automatic idle_inputs();
        issue_valid = 0; issue_we = 0; issue_rd = 0;
        wb_valid = 0; wb_we = 0; wb_rd = 0;
        kill_valid = 0; kill_rd0 = 0; kill_rd1 = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":busy_vec"}, busy_vec, model_busy());
        chk({tag, ":inflight"}, 32'(inflight_cnt), 32'(m_tot));
        chk({tag, ":sb_err"}, 32'(sb_err), 32'(m_err));
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic cycle(input string tag);
        #1;
        chk({tag, ":stall"}, 32'(data_stall_flag), 32'(model_stall()));
        @(posedge clk);
        model_step();
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        rf_re = 0;
        model_clear();
        #1;
        check_state("reset_low");
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_clear();
        idle_inputs();

        // Reset state and idle read
        do_reset();
        rf_re = 1; rs1 = 5; rs2 = 0;
        cycle("reset_chk");
        chk("reset_busy_const", busy_vec, 32'h0);

        // Basic RAW on x5
        issue_valid = 1; issue_we = 1; issue_rd = 5; rf_re = 0;
        cycle("raw_issue");
        idle_inputs(); rf_re = 1; rs1 = 0; rs2 = 5;
        cycle("raw_c2");
        chk("raw_busy5", 32'(busy_vec[5]), 32'd1);
        cycle("raw_c3");
        wb_valid = 1; wb_we = 1; wb_rd = 5;
        #1 chk("raw_wb_cycle_stall", 32'(data_stall_flag), 32'd1);
        cycle("raw_c4");
        idle_inputs();
        cycle("raw_c5");
        chk("raw_c5_stall", 32'(data_stall_flag), 32'd0);

        // Same-cycle issue and wb to x7
        issue_valid = 1; issue_we = 1; issue_rd = 7; rf_re = 0;
        cycle("same_setup");
        wb_valid = 1; wb_we = 1; wb_rd = 7;
        cycle("same_cycle");
        chk("same_inflight", 32'(inflight_cnt), 32'd1);
        idle_inputs(); wb_valid = 1; wb_we = 1; wb_rd = 7;
        cycle("same_drain");

        // Flush of two in-flight writers
        idle_inputs(); issue_valid = 1; issue_we = 1; issue_rd = 3;
        cycle("flush_i3");
        issue_rd = 9;
        cycle("flush_i9");
        idle_inputs(); kill_valid = 2'b11; kill_rd0 = 9; kill_rd1 = 3;
        cycle("flush_kill");
        chk("flush_empty", busy_vec, 32'h0);

        // x0 and rf_re gating
        idle_inputs(); issue_valid = 1; issue_we = 1; issue_rd = 0;
        cycle("x0_issue");
        issue_rd = 4;
        cycle("x4_issue");
        idle_inputs(); rf_re = 1; rs1 = 0; rs2 = 0;
        cycle("x0_read");
        rf_re = 0; rs1 = 4;
        cycle("no_re");
        rf_re = 1;
        cycle("re_busy");
        chk("re_busy_stall", 32'(data_stall_flag), 32'd1);
        rf_re = 0;

        // Saturation on x2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1; issue_we = 1; issue_rd = 2;
            cycle("sat_issue");
        end
        idle_inputs();
        chk("sat_err", 32'(sb_err), 32'd1);

        // Underflow on idle register
        do_reset();
        wb_valid = 1; wb_we = 1; wb_rd = 11;
        cycle("underflow");
        idle_inputs();
        chk("underflow_err", 32'(sb_err), 32'd1);

        // Async reset mid-stream
        do_reset();
        issue_valid = 1; issue_we = 1; issue_rd = 6;
        cycle("pre_async");
        issue_rd = 8;
        cycle("pre_async2");
        #2 rst_n = 0;
        model_clear();
        #1 check_state("async_rst");
        idle_inputs();
        @(negedge clk) rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset();
            idle_inputs();
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_we    = ($urandom_range(0, 3) != 0);
            issue_rd    = 5'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 1) == 1);
            wb_we       = ($urandom_range(0, 3) != 0);
            wb_rd       = 5'($urandom_range(0, 7));
            for (int k = 1; k < 8; k++)
                if (m_cnt[k] != 0 && $urandom_range(0, 2) == 0) wb_rd = 5'(k);
            if ($urandom_range(0, 9) == 0) begin
                kill_valid = 2'($urandom_range(1, 3));
                kill_rd0   = 5'($urandom_range(0, 7));
                kill_rd1   = 5'($urandom_range(0, 7));
            end
            rf_re = ($urandom_range(0, 3) != 0);
            rs1   = 5'($urandom_range(0, 7));
            rs2   = 5'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks, per architectural register, how many issued but not yet retired instructions will write it.
- Sits beside the ID stage of the 5-stage RV32I pipeline. ID marks its destination register busy at issue; MEM/WB clears it at writeback; the flush logic cancels it for killed instructions.
- Produces the data stall flag consumed by the pipeline control.
- Replaces per-stage rd comparators with registered state, so the hazard check no longer depends on pipeline depth.

Parameters:
- NREG, 32, number of architectural registers (x0..x31).
- CNT_W, 2, width of each per-register pending counter (max 2^CNT_W-1 in flight per register).
- TOT_W, 3, width of total in-flight write counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction leaves ID this cycle (not stalled, not flushed)
- issue_we  in  1  issuing instruction writes rd
- issue_rd  in  5  destination of issuing instruction
- wb_valid  in  1  MEM/WB instruction retires this cycle
- wb_we  in  1  retiring instruction writes rd
- wb_rd  in  5  destination of retiring instruction
- kill_valid  in  2  bit i: in-flight instruction i (0 = ID/EXE, 1 = EXE/MEM) is squashed this cycle
- kill_rd0  in  5  destination of killed ID/EXE instruction
- kill_rd1  in  5  destination of killed EXE/MEM instruction
- rf_re  in  1  instruction in ID reads the register file
- rf_rd_regnum_1  in  5  rs1 of instruction in ID
- rf_rd_regnum_2  in  5  rs2 of instruction in ID
- data_stall_flag  out  1  ID must stall (combinational)
- busy_vec  out  NREG  bit r = counter[r] != 0 (registered state)
- inflight_cnt  out  TOT_W  total pending writes
- sb_err  out  1  sticky over/underflow error

Behaviour:
- Reset: rst_n low asynchronously clears all counters, inflight_cnt and sb_err. All outputs are 0 during reset.
- x0:
  - Never tracked; any event with rd = 0 is ignored.
  - counter[0] is constant 0.
  - A read of x0 never stalls.
- Events (each applies only when its valid is high):
  - issue: +1 when issue_valid & issue_we.
  - wb: -1 when wb_valid & wb_we.
  - kill0 / kill1: -1 each. The kill sources carry only valid + rd; the flush unit asserts kill_valid only for instructions that write rd.
- Per-cycle update, for every register r:
  - counter[r] <= counter[r] + (#increments to r) - (#decrements to r), computed in a signed CNT_W+2 bit temporary.
  - Up to 4 events can hit the same r in one cycle. All are summed, never prioritised.
  - Example: issue and wb to the same r in one cycle → no change.
- Saturation:
  - Sum > 2^CNT_W-1: clamp to max and set sb_err.
  - Sum < 0: clamp to 0 and set sb_err.
  - sb_err clears only on reset.
- inflight_cnt: updated with the same net delta summed over all registers, with the same clamping rules.
- Stall:
  - data_stall_flag = rf_re & ((rs1 != 0 & counter[rs1] != 0) | (rs2 != 0 & counter[rs2] != 0)).
  - Uses pre-update (current) counters. A register being written back this cycle still stalls, because the register file commits on the same edge and does not bypass.
- Issue/stall interlock: the pipeline never asserts issue_valid while data_stall_flag is high. If it does anyway, the increment still applies; no error is flagged.
- Latency: an event at edge N is visible in busy_vec / data_stall_flag from edge N+1.
- Reset mid-operation: all state discards immediately; no pending writes survive.

Decomposition:
- Shared package `pipe_pkg`:
  - REG_W = 5, NREG, CNT_W.
  - Kill-slot index constants: KILL_IDEXE = 0, KILL_EXEMEM = 1.
- Sub-module `sb_cnt_cell`: one register's counter.
  - Inputs: inc, dec count (0..3).
  - Outputs: counter, nonzero, err.
  - Instantiated NREG-1 times via generate; slot 0 is tied to zero.

Test Plan:
- Reset check: after reset release, busy_vec = 0, inflight_cnt = 0, sb_err = 0; rf_re = 1, rs1 = 5 → data_stall_flag = 0.
- Basic RAW: issue rd = 5 at cycle 1; ID reads rs2 = 5 at cycles 2-4 → stall = 1. wb rd = 5 at cycle 4 → stall still 1 in cycle 4; cycle 5 → stall = 0, busy_vec[5] = 0.
- Same-cycle issue and wb: counter[7] = 1; issue rd = 7 and wb rd = 7 in the same cycle → counter[7] stays 1, inflight_cnt unchanged.
- Flush: issue rd = 3, then rd = 9; assert kill_valid = 2'b11 with kill_rd0 = 9, kill_rd1 = 3 → next cycle busy_vec = 0, inflight_cnt = 0.
- x0 and rf_re: issue rd = 0 → busy_vec unchanged. rs1 = 0 → no stall. rf_re = 0 with rs1 busy → stall = 0.
- Error paths: 4 issues to rd = 2 with no wb → counter saturates at 3, sb_err = 1. Separately, a wb to an idle register → counter stays 0, sb_err = 1. Async reset mid-stream clears everything within the same cycle.
